seg_execute_ex_mem_latch: RTL and testbench

//  EX/MEM pipeline register placed directly after the execute-stage ALU. Captures ALU result,

---
 rtl/seg_execute_ex_mem_latch.sv | 97 +++++++++
 tb/tb_seg_execute_ex_mem_latch.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seg_execute_ex_mem_latch.sv
// seg_execute_ex_mem_latch: EX/MEM pipeline register with BEQ/BNE redirect, stall, flush, squash; optional counters via EXMEM_PERF_CNT_EN
module seg_execute_ex_mem_latch #(
    parameter int LEN    = 32,
    parameter int NB_REG = 5,
    parameter int NB_CNT = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [LEN-1:0]    i_alu_out,
    input  logic              i_zero,
    input  logic [LEN-1:0]    i_data_b,
    input  logic [NB_REG-1:0] i_rd,
    input  logic [LEN-1:0]    i_branch_target,
    input  logic [5:0]        i_ctl,
    output logic              o_valid,
    output logic [LEN-1:0]    o_alu_out,
    output logic [LEN-1:0]    o_data_b,
    output logic [NB_REG-1:0] o_rd,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_reg_write,
    output logic              o_mem_to_reg,
    output logic              o_pc_src,
    output logic [LEN-1:0]    o_branch_target,
    output logic [NB_CNT-1:0] o_instr_cnt,
    output logic [NB_CNT-1:0] o_bubble_cnt
);
    logic              load, bubble, keep, taken;
    logic              valid_q, taken_q;
    logic [3:0]        ctl_q;
    logic [LEN-1:0]    alu_q, data_b_q, target_q;
    logic [NB_REG-1:0] rd_q;

    assign load   = i_enable & ~i_stall;
    assign bubble = i_flush | o_pc_src;
    assign keep   = i_valid & ~bubble;
    assign taken  = i_valid & ((i_ctl[5] & i_zero) | (i_ctl[4] & ~i_zero));

    // Latch EX results on loading edges; a redirect in flight squashes the wrong-path
    // instruction, which also drops taken_q so the pulse lasts one loading cycle and
    // holds unchanged through stall or disabled cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            ctl_q    <= '0;
            alu_q    <= '0;
            data_b_q <= '0;
            rd_q     <= '0;
            target_q <= '0;
        end else if (load) begin
            valid_q  <= keep;
            taken_q  <= keep & taken;
            ctl_q    <= bubble ? '0 : i_ctl[3:0];
            alu_q    <= bubble ? '0 : i_alu_out;
            data_b_q <= bubble ? '0 : i_data_b;
            rd_q     <= bubble ? '0 : i_rd;
            target_q <= bubble ? '0 : i_branch_target;
        end
    end

    assign o_valid         = valid_q;
    assign o_alu_out       = alu_q;
    assign o_data_b        = data_b_q;
    assign o_rd            = rd_q;
    assign o_mem_read      = valid_q & ctl_q[3];
    assign o_mem_write     = valid_q & ctl_q[2];
    assign o_reg_write     = valid_q & ctl_q[1];
    assign o_mem_to_reg    = valid_q & ctl_q[0];
    assign o_pc_src        = taken_q;
    assign o_branch_target = target_q;

`ifdef EXMEM_PERF_CNT_EN
    logic [NB_CNT-1:0] instr_cnt, bubble_cnt;

    // Count real instructions versus bubbles on each loading edge, wrapping naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instr_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (load) begin
            instr_cnt  <= instr_cnt + NB_CNT'(keep);
            bubble_cnt <= bubble_cnt + NB_CNT'(~keep);
        end
    end

    assign o_instr_cnt  = instr_cnt;
    assign o_bubble_cnt = bubble_cnt;
`else
    assign o_instr_cnt  = '0;
    assign o_bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_seg_execute_ex_mem_latch.sv
// tb_seg_execute_ex_mem_latch: scoreboard bench for the EX/MEM latch
module tb_seg_execute_ex_mem_latch;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        en = 1'b1, st = 1'b0, fl = 1'b0, v = 1'b0, z = 1'b0;
    logic [31:0] alu = '0, db = '0, tgt = '0;
    logic [4:0]  rd = '0;
    logic [5:0]  ctl = '0;
    logic        o_valid, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg, o_pc_src;
    logic [31:0] o_alu_out, o_data_b, o_branch_target, o_instr_cnt, o_bubble_cnt;
    logic [4:0]  o_rd;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu, db, tgt;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic        pc;
        logic [31:0] ic, bc;
    } exp_t;

    exp_t m, q[$];
    int checks = 0, failures = 0;

    seg_execute_ex_mem_latch dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_stall(st), .i_flush(fl),
        .i_valid(v), .i_alu_out(alu), .i_zero(z), .i_data_b(db), .i_rd(rd),
        .i_branch_target(tgt), .i_ctl(ctl), .o_valid(o_valid), .o_alu_out(o_alu_out),
        .o_data_b(o_data_b), .o_rd(o_rd), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg), .o_pc_src(o_pc_src),
        .o_branch_target(o_branch_target), .o_instr_cnt(o_instr_cnt), .o_bubble_cnt(o_bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".valid"}, 64'(o_valid), 64'(e.valid));
        check({tag, ".alu"}, 64'(o_alu_out), 64'(e.alu));
        check({tag, ".data_b"}, 64'(o_data_b), 64'(e.db));
        check({tag, ".rd"}, 64'(o_rd), 64'(e.rd));
        check({tag, ".ctl"}, 64'({o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg}), 64'(e.ctl));
        check({tag, ".pc_src"}, 64'(o_pc_src), 64'(e.pc));
        check({tag, ".target"}, 64'(o_branch_target), 64'(e.tgt));
        check({tag, ".instr_cnt"}, 64'(o_instr_cnt), 64'(e.ic));
        check({tag, ".bubble_cnt"}, 64'(o_bubble_cnt), 64'(e.bc));
    endtask

    task automatic drive(input string tag, input logic e_en, e_st, e_fl, e_v,
                         input logic [31:0] e_alu, input logic e_z, input logic [31:0] e_db,
                         input logic [4:0] e_rd, input logic [31:0] e_tgt, input logic [5:0] e_ctl);
        logic bub, kp;
        exp_t e;
        en = e_en; st = e_st; fl = e_fl; v = e_v; alu = e_alu; z = e_z;
        db = e_db; rd = e_rd; tgt = e_tgt; ctl = e_ctl;
        if (e_en && !e_st) begin
            bub = e_fl | m.pc;
            kp = e_v & ~bub;
            m.valid = kp;
            m.alu = bub ? 32'h0 : e_alu;
            m.db = bub ? 32'h0 : e_db;
            m.rd = bub ? 5'h0 : e_rd;
            m.tgt = bub ? 32'h0 : e_tgt;
            m.ctl = kp ? e_ctl[3:0] : 4'h0;
            m.pc = kp & ((e_ctl[5] & e_z) | (e_ctl[4] & ~e_z));
`ifdef EXMEM_PERF_CNT_EN
            if (kp) m.ic = m.ic + 1; else m.bc = m.bc + 1;
`endif
        end
        q.push_back(m);
        @(posedge clk);
        #1;
        if (q.size() == 0) check({tag, ".sb_empty"}, 64'd1, 64'd0);
        else begin
            e = q.pop_front();
            check_out(tag, e);
        end
    endtask

    initial begin
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", m);
        @(negedge clk);
        rst_n = 1'b1;

        drive("load", 1, 0, 0, 1, 32'h10, 0, 32'h0, 5'd8, 32'h0, 6'b000010);
        drive("beq_taken", 1, 0, 0, 1, 32'h0, 1, 32'h0, 5'd0, 32'h40, 6'b100000);
        drive("squash", 1, 0, 0, 1, 32'h99, 0, 32'h55, 5'd3, 32'h0, 6'b000100);
        drive("after_squash", 1, 0, 0, 1, 32'h20, 0, 32'h66, 5'd4, 32'h0, 6'b000100);
        drive("bne_not_taken", 1, 0, 0, 1, 32'h30, 1, 32'h0, 5'd0, 32'h80, 6'b010000);
        drive("after_bne", 1, 0, 0, 1, 32'h34, 0, 32'h0, 5'd9, 32'h0, 6'b001011);
        drive("bne_taken", 1, 0, 0, 1, 32'h0, 0, 32'h0, 5'd0, 32'hC0, 6'b010000);
        for (int i = 0; i < 3; i++)
            drive("stall_hold", 1, 1, i == 1, 1, 32'h100 + i, i[0], 32'h7, 5'd2 + 5'(i), 32'h4, 6'b001110);
        drive("disable_hold", 0, 0, 1, 1, 32'hDEAD, 1, 32'h1, 5'd1, 32'h8, 6'b100010);
        drive("stall_release", 1, 0, 0, 1, 32'hBEEF, 0, 32'h1, 5'd1, 32'h8, 6'b000110);
        drive("stall_flush_a", 1, 0, 0, 1, 32'h44, 0, 32'h2, 5'd5, 32'h0, 6'b000010);
        drive("stall_flush_b", 1, 1, 1, 1, 32'h48, 0, 32'h3, 5'd6, 32'h0, 6'b000010);
        drive("flush_load", 1, 0, 1, 1, 32'h4C, 0, 32'h3, 5'd6, 32'h0, 6'b000110);

        drive("pre_reset_beq", 1, 0, 0, 1, 32'h0, 1, 32'h0, 5'd0, 32'h200, 6'b100000);
        #2;
        rst_n = 1'b0;
        #1;
        m = '0;
        check_out("mid_reset", m);
        @(negedge clk);
        rst_n = 1'b1;

        drive("cnt0", 1, 0, 0, 1, 32'h1, 0, 32'h0, 5'd1, 32'h0, 6'b000010);
        drive("cnt1", 1, 0, 1, 1, 32'h2, 0, 32'h0, 5'd2, 32'h0, 6'b000010);
        drive("cnt2", 1, 0, 0, 1, 32'h3, 0, 32'h0, 5'd3, 32'h0, 6'b000010);
        drive("cnt3", 1, 0, 1, 1, 32'h4, 0, 32'h0, 5'd4, 32'h0, 6'b000010);
        drive("cnt4", 1, 0, 0, 1, 32'h5, 0, 32'h0, 5'd5, 32'h0, 6'b000010);
`ifdef EXMEM_PERF_CNT_EN
        check("cnt_instr_total", 64'(o_instr_cnt), 64'd3);
        check("cnt_bubble_total", 64'(o_bubble_cnt), 64'd2);
`else
        check("cnt_instr_tied", 64'(o_instr_cnt), 64'd0);
        check("cnt_bubble_tied", 64'(o_bubble_cnt), 64'd0);
`endif

        for (int i = 0; i < 60; i++)
            drive("rand", $urandom_range(7) != 0, $urandom_range(4) == 0, $urandom_range(5) == 0,
                  1'($urandom), $urandom, 1'($urandom), $urandom, 5'($urandom),
                  $urandom, 6'($urandom));

        if (q.size() != 0) check("sb_leftover", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
